// File: rtl/data_ip_axil_regs.sv
// AXI4-Lite slave holding four 32-bit registers for data_ip.
// Independent write and read channel FSMs share only the register array.
module data_ip_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3,
   output logic [3:0]                      REG_WR_PULSE
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int SW = DW / 8;

   localparam logic [0:0] WR_IDLE = 1'b0;
   localparam logic [0:0] WR_RESP = 1'b1;
   localparam logic [0:0] RD_IDLE = 1'b0;
   localparam logic [0:0] RD_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Merge enabled byte lanes of new data over the old register value.
   function automatic logic [DW-1:0] f_apply_strb(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
      logic [DW-1:0] v;
      v = old_v;
      for (int k = 0; k < SW; k++) begin
         if (strb[k]) begin
            v[8*k +: 8] = new_v[8*k +: 8];
         end else begin
            v[8*k +: 8] = old_v[8*k +: 8];
         end
      end
      return v;
   endfunction

   function automatic logic f_in_range(input logic [AW-1:0] addr);
      return (addr[AW-1:4] == {(AW-4){1'b0}});
   endfunction

   logic [0:0]    r_wr_state;
   logic          r_aw_held;
   logic          r_w_held;
   logic [AW-1:0] r_awaddr;
   logic [DW-1:0] r_wdata;
   logic [SW-1:0] r_wstrb;
   logic          r_bvalid;
   logic [1:0]    r_bresp;
   logic [DW-1:0] r_regs [0:3];
   logic [3:0]    r_wr_pulse;
   logic [0:0]    r_rd_state;
   logic          r_rvalid;
   logic [DW-1:0] r_rdata;
   logic [1:0]    r_rresp;

   logic          w_awready;
   logic          w_wready;
   logic          w_arready;
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_ar_hs;
   logic [AW-1:0] w_wr_addr;
   logic [DW-1:0] w_wr_data;
   logic [SW-1:0] w_wr_strb;
   logic          w_commit;
   logic          w_wr_ok;
   logic [1:0]    w_wr_idx;
   logic [1:0]    w_rd_idx;
   logic          w_unused_ok;

   assign w_awready = (r_wr_state == WR_IDLE) && !r_aw_held;
   assign w_wready  = (r_wr_state == WR_IDLE) && !r_w_held;
   assign w_arready = (r_rd_state == RD_IDLE);
   assign w_aw_hs   = S_AXI_AWVALID && w_awready;
   assign w_w_hs    = S_AXI_WVALID && w_wready;
   assign w_ar_hs   = S_AXI_ARVALID && w_arready;
   assign w_rd_idx  = S_AXI_ARADDR[3:2];

   // Select latched or live AW/W fields and detect the commit cycle.
   always_comb begin
      w_wr_addr = S_AXI_AWADDR;
      w_wr_data = S_AXI_WDATA;
      w_wr_strb = S_AXI_WSTRB;
      if (r_aw_held) begin
         w_wr_addr = r_awaddr;
      end else begin
         w_wr_addr = S_AXI_AWADDR;
      end
      if (r_w_held) begin
         w_wr_data = r_wdata;
         w_wr_strb = r_wstrb;
      end else begin
         w_wr_data = S_AXI_WDATA;
         w_wr_strb = S_AXI_WSTRB;
      end
   end

   assign w_commit = (r_wr_state == WR_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
   assign w_wr_ok  = f_in_range(w_wr_addr);
   assign w_wr_idx = w_wr_addr[3:2];

   // Write channel: latch AW/W independently, commit, then hold B until accepted.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_state <= WR_IDLE;
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awaddr   <= {AW{1'b0}};
         r_wdata    <= {DW{1'b0}};
         r_wstrb    <= {SW{1'b0}};
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
      end else begin
         case (r_wr_state)
            WR_IDLE: begin
               if (w_aw_hs) begin
                  r_aw_held <= 1'b1;
                  r_awaddr  <= S_AXI_AWADDR;
               end
               if (w_w_hs) begin
                  r_w_held <= 1'b1;
                  r_wdata  <= S_AXI_WDATA;
                  r_wstrb  <= S_AXI_WSTRB;
               end
               if (w_commit) begin
                  r_wr_state <= WR_RESP;
                  r_bvalid   <= 1'b1;
                  r_bresp    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            WR_RESP: begin
               if (r_bvalid && S_AXI_BREADY) begin
                  r_wr_state <= WR_IDLE;
                  r_bvalid   <= 1'b0;
                  r_aw_held  <= 1'b0;
                  r_w_held   <= 1'b0;
               end
            end
            default: begin
               r_wr_state <= WR_IDLE;
               r_bvalid   <= 1'b0;
               r_aw_held  <= 1'b0;
               r_w_held   <= 1'b0;
            end
         endcase
      end
   end

   // Register array update and one-cycle write pulse on in-range commits.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int n = 0; n < 4; n++) begin
            r_regs[n] <= {DW{1'b0}};
         end
         r_wr_pulse <= 4'b0000;
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (w_commit && w_wr_ok && (w_wr_idx == 2'(n))) begin
               r_regs[n]     <= f_apply_strb(r_regs[n], w_wr_data, w_wr_strb);
               r_wr_pulse[n] <= 1'b1;
            end else begin
               r_wr_pulse[n] <= 1'b0;
            end
         end
      end
   end

   // Read channel: capture pre-write register value on AR, hold R until accepted.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rd_state <= RD_IDLE;
         r_rvalid   <= 1'b0;
         r_rdata    <= {DW{1'b0}};
         r_rresp    <= RESP_OKAY;
      end else begin
         case (r_rd_state)
            RD_IDLE: begin
               if (w_ar_hs) begin
                  r_rd_state <= RD_DATA;
                  r_rvalid   <= 1'b1;
                  if (f_in_range(S_AXI_ARADDR)) begin
                     r_rdata <= r_regs[w_rd_idx];
                     r_rresp <= RESP_OKAY;
                  end else begin
                     r_rdata <= {DW{1'b0}};
                     r_rresp <= RESP_SLVERR;
                  end
               end
            end
            RD_DATA: begin
               if (r_rvalid && S_AXI_RREADY) begin
                  r_rd_state <= RD_IDLE;
                  r_rvalid   <= 1'b0;
               end
            end
            default: begin
               r_rd_state <= RD_IDLE;
               r_rvalid   <= 1'b0;
            end
         endcase
      end
   end

   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = w_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign REG0          = r_regs[0];
   assign REG1          = r_regs[1];
   assign REG2          = r_regs[2];
   assign REG3          = r_regs[3];
   assign REG_WR_PULSE  = r_wr_pulse;

   // Protection bits and sub-word address bits carry no meaning here.
   assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_data_ip_axil_regs.sv
// Directed bench for data_ip_axil_regs with hand-computed expectations.
module tb_data_ip_axil_regs;

   logic        clk;
   logic        areset;
   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] reg0, reg1, reg2, reg3;
   logic [3:0]  reg_wr_pulse;

   int tests = 0;
   int fails = 0;

   data_ip_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
      .ACLK(clk), .ARESET(areset),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .REG0(reg0), .REG1(reg1), .REG2(reg2), .REG3(reg3), .REG_WR_PULSE(reg_wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
         $error("%s observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int stall, input logic [1:0] exp_resp, input logic [3:0] exp_pulse);
      int cnt;
      logic aw_hs, w_hs;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      cnt = 0;
      while ((awvalid || wvalid) && cnt < 20) begin
         #1;
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         if (aw_hs) awvalid = 1'b0;
         if (w_hs) wvalid = 1'b0;
         cnt++;
      end
      chk("wr_accept", 32'({awvalid, wvalid}), 32'h0);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_bvalid_latency", 32'(bvalid), 32'h1);
      chk("wr_bresp", 32'(bresp), 32'(exp_resp));
      chk("wr_pulse", 32'(reg_wr_pulse), 32'(exp_pulse));
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("wr_stall_bvalid", 32'(bvalid), 32'h1);
         chk("wr_stall_bresp", 32'(bresp), 32'(exp_resp));
         chk("wr_stall_ready", 32'({awready, wready}), 32'h0);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("wr_b_done", 32'({bvalid, reg_wr_pulse}), 32'h0);
   endtask

   task automatic axi_read(input logic [5:0] a, input int stall,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      int cnt;
      logic ar_hs;
      araddr = a; arvalid = 1'b1;
      cnt = 0;
      while (arvalid && cnt < 20) begin
         #1;
         ar_hs = arvalid && arready;
         tick();
         if (ar_hs) arvalid = 1'b0;
         cnt++;
      end
      chk("rd_accept", 32'(arvalid), 32'h0);
      arvalid = 1'b0;
      chk("rd_rvalid_latency", 32'(rvalid), 32'h1);
      chk("rd_rdata", rdata, exp_data);
      chk("rd_rresp", 32'(rresp), 32'(exp_resp));
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("rd_stall_rvalid", 32'(rvalid), 32'h1);
         chk("rd_stall_rdata", rdata, exp_data);
         chk("rd_stall_arready", 32'(arready), 32'h0);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rd_r_done", 32'(rvalid), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      areset = 1'b1;
      awaddr = 6'h0; awprot = 3'b000; awvalid = 1'b0;
      wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
      araddr = 6'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      areset = 1'b0;

      // Reset state
      chk("rst_ready", 32'({awready, wready, arready}), 32'h7);
      chk("rst_valid", 32'({bvalid, rvalid}), 32'h0);
      chk("rst_resp", 32'({bresp, rresp}), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_regs", reg0 | reg1 | reg2 | reg3, 32'h0);
      chk("rst_pulse", 32'(reg_wr_pulse), 32'h0);

      // Basic writes and readback
      axi_write(6'h00, 32'h1, 4'hF, 0, 2'b00, 4'b0001);
      axi_write(6'h04, 32'h2, 4'hF, 0, 2'b00, 4'b0010);
      axi_write(6'h08, 32'h3, 4'hF, 0, 2'b00, 4'b0100);
      axi_write(6'h0C, 32'h4, 4'hF, 0, 2'b00, 4'b1000);
      axi_read(6'h00, 0, 32'h1, 2'b00);
      axi_read(6'h04, 0, 32'h2, 2'b00);
      axi_read(6'h08, 0, 32'h3, 2'b00);
      axi_read(6'h0C, 0, 32'h4, 2'b00);

      // Byte strobes
      axi_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 2'b00, 4'b0010);
      axi_write(6'h04, 32'h11223344, 4'b0101, 0, 2'b00, 4'b0010);
      axi_read(6'h04, 0, 32'hAA22CC44, 2'b00);

      // AW three cycles ahead of W
      awaddr = 6'h08; awvalid = 1'b1;
      #1;
      chk("aw_first_awready", 32'(awready), 32'h1);
      tick();
      awvalid = 1'b0;
      chk("aw_first_held", 32'({awready, wready, bvalid}), 32'b010);
      tick();
      tick();
      wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("aw_first_bvalid", 32'(bvalid), 32'h1);
      chk("aw_first_reg2", reg2, 32'h55);
      chk("aw_first_pulse", 32'(reg_wr_pulse), 32'h4);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("aw_first_done", 32'({bvalid, awready, wready}), 32'b011);

      // W three cycles ahead of AW
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      #1;
      chk("w_first_wready", 32'(wready), 32'h1);
      tick();
      wvalid = 1'b0;
      chk("w_first_held", 32'({awready, wready, bvalid}), 32'b100);
      tick();
      tick();
      awaddr = 6'h08; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("w_first_bvalid", 32'(bvalid), 32'h1);
      chk("w_first_reg2", reg2, 32'h77);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("w_first_done", 32'(bvalid), 32'h0);

      // Empty strobe still pulses but leaves data alone
      axi_write(6'h08, 32'hFFFFFFFF, 4'h0, 0, 2'b00, 4'b0100);
      chk("strb0_reg2", reg2, 32'h77);

      // Back-pressure on B and R
      axi_write(6'h0C, 32'h12345678, 4'hF, 5, 2'b00, 4'b1000);
      axi_read(6'h0C, 5, 32'h12345678, 2'b00);

      // Out-of-range accesses
      axi_write(6'h10, 32'hDEAD, 4'hF, 0, 2'b10, 4'b0000);
      chk("oor_reg0", reg0, 32'h1);
      chk("oor_reg1", reg1, 32'hAA22CC44);
      chk("oor_reg2", reg2, 32'h77);
      chk("oor_reg3", reg3, 32'h12345678);
      axi_read(6'h3C, 0, 32'h0, 2'b10);

      // Same-edge write and read of register 0
      axi_write(6'h00, 32'h7, 4'hF, 0, 2'b00, 4'b0001);
      awaddr = 6'h00; wdata = 32'h9; wstrb = 4'hF; araddr = 6'h00;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("same_edge_rvalid", 32'({rvalid, bvalid}), 32'b11);
      chk("same_edge_rdata", rdata, 32'h7);
      chk("same_edge_reg0", reg0, 32'h9);

      // Reset while a response is pending
      areset = 1'b1;
      tick();
      chk("midrst_valid", 32'({bvalid, rvalid}), 32'h0);
      chk("midrst_reg0", reg0, 32'h0);
      chk("midrst_reg1", reg1, 32'h0);
      areset = 1'b0;
      tick();
      chk("midrst_ready", 32'({awready, wready, arready}), 32'h7);
      axi_read(6'h00, 0, 32'h0, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_ip_axil_regs.md
# data_ip_axil_regs

AXI4-Lite slave register file for `data_ip`: the responder end of the bus driven by the master VIP in the block-level bench. It holds four 32-bit read/write registers at byte offsets 0x0–0xC, answers one write and one read transaction at a time, and exports register contents and write pulses to the fabric. Reads and writes run in independent channel FSMs sharing only the register array.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, address width; decoded window 0x00–0x3F.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- REG0..REG3  out  32 each  current register values.
- REG_WR_PULSE  out  4  one-cycle pulse, bit n set on the commit cycle of a write to register n.

## Operation
- Address decode: index = addr[3:2]. Any addr >= 0x10 is out of range. addr[1:0] is ignored.
- Write FSM states: WR_IDLE and WR_RESP.
  - In WR_IDLE, AWREADY = !aw_held and WREADY = !w_held. AW and W are accepted independently, in either order or together, and each is latched on its handshake.
  - When both are held, or complete in the same cycle, the write commits on that edge. For an in-range address, each byte lane with WSTRB[k]=1 updates; a WSTRB of 0000 is legal and changes nothing. For an out-of-range address, no register changes and BRESP=SLVERR.
  - After the commit, the FSM moves to WR_RESP. BVALID=1 and AWREADY=WREADY=0.
  - The FSM returns to WR_IDLE on the edge where BVALID&&BREADY. The held flags clear.
- Read FSM states: RD_IDLE and RD_DATA.
  - In RD_IDLE, ARREADY=1. On the handshake, RDATA/RRESP are loaded from the register value *before* any write committing on the same edge. Out-of-range reads return RDATA=0 and RRESP=SLVERR.
  - In RD_DATA, RVALID=1 and ARREADY=0. RDATA/RRESP are held stable until RVALID&&RREADY, which returns the FSM to RD_IDLE.
- REG_WR_PULSE is asserted only for in-range commits, including WSTRB=0000.

## Timing
- Reset values: REG0..3=0, BVALID=0, RVALID=0, BRESP=RRESP=00, RDATA=0, REG_WR_PULSE=0, AWREADY=WREADY=ARREADY=1 on the first cycle after reset deasserts. Held flags are cleared.
- Write latency: BVALID rises 1 cycle after the edge on which the second of AW/W handshakes. REG0..3 and REG_WR_PULSE reflect the write on that same cycle.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Throughput: at most one write per 2 cycles and one read per 2 cycles, with a zero-wait-state BREADY/RREADY.
- VALID is never dropped by the slave before its handshake. READY never depends combinationally on the same-cycle VALID.
- Reset asserted mid-transaction: the next edge forces all state to its reset values, and the in-flight response is abandoned.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=F, then read back each address → BRESP=OKAY each time, RDATA 0x1..0x4, RRESP=OKAY, REG_WR_PULSE bits 0..3 pulse once each.
- Write 0xAABBCCDD to 0x4 with WSTRB=F, then 0x11223344 with WSTRB=0101, then read 0x4 → RDATA=0xAA22CC44.
- AWVALID 3 cycles before WVALID (and separately the reverse), with data 0x55 to 0x8 → AWREADY drops after the AW handshake, commit on the W handshake edge, BVALID the next cycle, REG2=0x55.
- Hold BREADY=0 for 5 cycles after a write; hold RREADY=0 for 5 cycles after a read → BVALID/RVALID and BRESP/RDATA stay stable, AWREADY=WREADY=0 and ARREADY=0 during the respective wait.
- Write 0xDEAD to 0x10, then read 0x3C → BRESP=10 with REG0..3 unchanged and no REG_WR_PULSE; RRESP=10 with RDATA=0.
- Issue a write to 0x0 and a read of 0x0 on the same edge (REG0 previously 0x7, new data 0x9) → RDATA=0x7, REG0=0x9. Then assert ARESET while BVALID=1 → next cycle BVALID=0 and REG0=0.
